// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: a request strobe plus address out,
// a response strobe plus data back.
interface fetch_stage_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemValid;
    logic [31:0] IMemRdata;

    // Handshake: IMemReq is a one-cycle strobe with IMemAddr valid in that cycle.
    // The memory returns exactly one IMemValid pulse, carrying IMemRdata, at least
    // one cycle later. There is no ready signal, and at most one request is
    // outstanding at any time.
    modport master (output IMemReq, IMemAddr, input IMemValid, IMemRdata);
    modport slave  (input IMemReq, IMemAddr, output IMemValid, IMemRdata);
endinterface

// File: rtl/fetch_stage.sv
// RISC-V instruction-fetch stage: owns the PC and drives a single-outstanding imem port.
// Optional FETCH_PERF_EN adds FetchCount/StallCount performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Stall,
    input  logic                 PCSrcE,
    input  logic [31:0]          PCTargetE,
    fetch_stage_if.master        imem,
    output logic [31:0]          InstrF,
    output logic [31:0]          PCPlus4F,
    output logic [31:0]          PCF,
    output logic                 FetchValidF,
    output logic [1:0]           o_dbg_state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          FetchCount,
    output logic [31:0]          StallCount
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        w_next_valid;
    logic        w_capture;
    logic        w_req;
    logic        w_consume;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    assign w_target   = PCTargetE & 32'hFFFF_FFFC;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_consume  = r_valid && !Stall && !PCSrcE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_valid <= w_next_valid;
            if (w_capture) begin
                r_instr <= imem.IMemRdata;
            end
        end
    end

    // A redirect always wins; a response that races it is simply not captured.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_valid = r_valid;
        w_capture    = 1'b0;
        w_req        = 1'b0;
        case (r_state)
            S_REQ: begin
                if (PCSrcE) begin
                    w_next_pc = w_target;
                end else begin
                    w_req        = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (PCSrcE) begin
                    w_next_pc    = w_target;
                    w_next_state = imem.IMemValid ? S_REQ : S_DROP;
                end else if (imem.IMemValid) begin
                    w_capture    = 1'b1;
                    w_next_valid = 1'b1;
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    w_next_pc    = w_target;
                    w_next_valid = 1'b0;
                    w_next_state = S_REQ;
                end else if (!Stall) begin
                    w_next_pc    = w_pc_plus4;
                    w_next_valid = 1'b0;
                    w_next_state = S_REQ;
                end
            end
            S_DROP: begin
                if (PCSrcE) begin
                    w_next_pc = w_target;
                end
                if (imem.IMemValid) begin
                    w_next_state = S_REQ;
                end
            end
            default: begin
                w_next_state = S_REQ;
                w_next_valid = 1'b0;
            end
        endcase
    end

    // The request strobe is masked during reset because the FSM sits in S_REQ there.
    assign imem.IMemReq  = w_req & rst_n;
    assign imem.IMemAddr = r_pc;

    assign PCF         = r_pc;
    assign PCPlus4F    = w_pc_plus4;
    assign FetchValidF = r_valid;
    assign InstrF      = r_valid ? r_instr : NOP_INSTR;
    assign o_dbg_state = r_state;

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (w_consume) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (r_valid && Stall && !PCSrcE) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign FetchCount = r_fetch_count;
    assign StallCount = r_stall_count;
`else
    logic w_unused_consume;
    assign w_unused_consume = w_consume;
`endif

    // A response is only legal while a request is outstanding.
    a_no_stray_response: assert property (
        @(posedge clk) disable iff (!rst_n)
        imem.IMemValid |-> (r_state == S_WAIT || r_state == S_DROP)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios, then randomized stall/redirect/latency
// traffic checked against an architectural model of the fetched instruction stream.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        pcsrc = 1'b0;
  logic [31:0] target = 32'd0;
  logic [31:0] instr_f;
  logic [31:0] pcplus4_f;
  logic [31:0] pc_f;
  logic        fetch_valid_f;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  fetch_stage_if imem_if ();

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Stall       (stall),
    .PCSrcE      (pcsrc),
    .PCTargetE   (target),
    .imem        (imem_if),
    .InstrF      (instr_f),
    .PCPlus4F    (pcplus4_f),
    .PCF         (pc_f),
    .FetchValidF (fetch_valid_f),
    .o_dbg_state (dbg_state)
`ifdef FETCH_PERF_EN
    ,
    .FetchCount  (fetch_count),
    .StallCount  (stall_count)
`endif
  );

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          passed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  logic        exp_valid;
  logic        pending;
  logic        live;
  logic [31:0] req_addr;
  int          wait_cnt;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          consumes = 0;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else passed++;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_reset();
    model_pc  = RESET_PC;
    exp_valid = 1'b0;
    pending   = 1'b0;
    live      = 1'b0;
    wait_cnt  = 0;
    req_addr  = 32'd0;
    m_fetch   = 32'd0;
    m_stall   = 32'd0;
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver: one cycle, inputs + memory, then sample ----------------
  task automatic cyc(input logic s, input logic p, input logic [31:0] t);
    logic delivered;
    logic exp_req;
    stall  = s;
    pcsrc  = p;
    target = t;
    delivered = 1'b0;
    imem_if.IMemValid = 1'b0;
    imem_if.IMemRdata = $urandom;
    if (pending) begin
      if (wait_cnt == 0) begin
        imem_if.IMemValid = 1'b1;
        imem_if.IMemRdata = mem_word(req_addr);
        pending   = 1'b0;
        delivered = 1'b1;
      end else begin
        wait_cnt--;
      end
    end
    #4;
    check("pcf", pc_f, model_pc);
    check("pcplus4", pcplus4_f, model_pc + 32'd4);
    check("valid", {31'd0, fetch_valid_f}, {31'd0, exp_valid});
    check("instr", instr_f, (exp_valid && exp_q.size() > 0) ? exp_q[0] : NOP_INSTR);
    exp_req = !pending && !delivered && !exp_valid && !p;
    check("imem_req", {31'd0, imem_if.IMemReq}, {31'd0, exp_req});
    if (imem_if.IMemReq) check("imem_addr", imem_if.IMemAddr, model_pc);
`ifdef FETCH_PERF_EN
    check("fetch_count", fetch_count, m_fetch);
    check("stall_count", stall_count, m_stall);
`endif
    if (imem_if.IMemReq) begin
      pending  = 1'b1;
      live     = 1'b1;
      req_addr = imem_if.IMemAddr;
      wait_cnt = $urandom_range(lat_hi, lat_lo) - 1;
    end
    if (p) begin
      if (exp_valid) void'(exp_q.pop_front());
      if (pending) live = 1'b0;
      model_pc  = t & 32'hFFFF_FFFC;
      exp_valid = 1'b0;
    end else if (exp_valid && !s) begin
      void'(exp_q.pop_front());
      model_pc  = model_pc + 32'd4;
      m_fetch   = m_fetch + 32'd1;
      consumes++;
      exp_valid = 1'b0;
    end else if (exp_valid) begin
      m_stall = m_stall + 32'd1;
    end else if (delivered && live) begin
      exp_q.push_back(mem_word(req_addr));
      exp_valid = 1'b1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    pcsrc = 1'b0;
    target = 32'd0;
    imem_if.IMemValid = 1'b0;
    imem_if.IMemRdata = 32'd0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    apply_reset();

    // First fetch with 1-cycle memory: REQ, response, hold/consume, next REQ.
    lat_lo = 1; lat_hi = 1;
    cyc(0, 0, 0);
    check("t1_req0", {31'd0, imem_if.IMemReq}, 32'd1);
    check("t1_addr0", imem_if.IMemAddr, 32'd0);
    tick();
    cyc(0, 0, 0); tick();
    cyc(0, 0, 0);
    check("t1_valid2", {31'd0, fetch_valid_f}, 32'd1);
    check("t1_instr2", instr_f, 32'h0050_0093);
    check("t1_plus4", pcplus4_f, 32'd4);
    tick();
    cyc(0, 0, 0);
    check("t1_pc3", pc_f, 32'd4);
    check("t1_req3", {31'd0, imem_if.IMemReq}, 32'd1);
    tick();

    // Four stalled cycles holding the fetched word, then a consume.
    cyc(0, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0);
      check("t2_hold_valid", {31'd0, fetch_valid_f}, 32'd1);
      check("t2_hold_pc", pc_f, 32'd4);
      check("t2_hold_instr", instr_f, mem_word(32'd4));
      check("t2_no_req", {31'd0, imem_if.IMemReq}, 32'd0);
      tick();
    end
    cyc(0, 0, 0);
`ifdef FETCH_PERF_EN
    check("t2_stall_cnt", stall_count, 32'd4);
`endif
    tick();

    // Redirect while waiting; the late response must be dropped.
    lat_lo = 3; lat_hi = 3;
    cyc(0, 0, 0); tick();
    cyc(0, 1, 32'h0000_0103); tick();
    cyc(0, 0, 0); tick();
    cyc(0, 0, 0); tick();
    lat_lo = 1; lat_hi = 1;
    cyc(0, 0, 0);
    check("t3_dropped", {31'd0, fetch_valid_f}, 32'd0);
    check("t3_req", {31'd0, imem_if.IMemReq}, 32'd1);
    check("t3_addr", imem_if.IMemAddr, 32'h0000_0100);
    tick();

    // Redirect together with Stall while holding.
    cyc(0, 0, 0); tick();
    cyc(1, 1, 32'h0000_0200); tick();
    cyc(0, 0, 0);
    check("t4_valid", {31'd0, fetch_valid_f}, 32'd0);
    check("t4_pc", pc_f, 32'h0000_0200);
`ifdef FETCH_PERF_EN
    check("t4_fetch_cnt", fetch_count, 32'd2);
`endif
    tick();

    // PC wrap at the top of the address space.
    cyc(0, 0, 0); tick();
    cyc(0, 1, 32'hFFFF_FFFE); tick();
    cyc(0, 0, 0); tick();
    cyc(0, 0, 0); tick();
    cyc(0, 0, 0);
    check("t5_plus4_wrap", pcplus4_f, 32'd0);
    tick();
    cyc(0, 0, 0);
    check("t5_pc_wrap", pc_f, 32'd0);
    tick();

    // Asynchronous reset while a request is outstanding.
    lat_lo = 3; lat_hi = 3;
    cyc(0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("t6_pc", pc_f, RESET_PC);
    check("t6_instr", instr_f, NOP_INSTR);
    check("t6_valid", {31'd0, fetch_valid_f}, 32'd0);
    check("t6_req", {31'd0, imem_if.IMemReq}, 32'd0);
    tick();
    apply_reset();
    lat_lo = 1; lat_hi = 1;
    cyc(0, 0, 0);
    check("t6_req_after", {31'd0, imem_if.IMemReq}, 32'd1);
    check("t6_addr_after", imem_if.IMemAddr, RESET_PC);
    tick();

    // Randomized traffic.
    lat_lo = 1; lat_hi = 3;
    consumes = 0;
    for (int i = 0; i < 3000; i++) begin
      logic s;
      logic p;
      logic [31:0] t;
      s = ($urandom_range(99) < 30);
      p = ($urandom_range(99) < 8);
      t = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
      cyc(s, p, t);
      tick();
    end
    check("progress", {31'd0, consumes > 200}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
